vp_seq: RTL
===========

VP_SEQ -- requirements
Module: vp_seq

Interface
REQ-001 SHALL have parameters, one per line:
- H_DISP, 1280, expected active pixels per line.
- V_DISP, 720, expected active lines per frame.
- FLUSH_FRAMES, 2, frames muted after an applied configuration change (range 1..15).

REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous active-high reset.
- cfg_cr/cfg_start/cfg_end/cfg_scaler/cfg_threshold  in  32 each  software-written values.
- cfg_wr  in  1  one-cycle strobe; cfg_* valid this cycle.
- sr_clr  in  1  clears sticky status bits.
- vi_vs  in  1  input vsync, active-high.
- vi_de  in  1  input data enable.
- act_cr/act_start/act_end/act_scaler/act_threshold  out  32 each  configuration driving the datapath.
- vp_mute  out  1  forces the datapath output to blank.
- busy  out  1  update pending or flush in progress.
- vp_sr  out  32  status word.
- frame_cnt  out  16  frame boundary counter.
- irq  out  1  one-cycle frame-boundary pulse.

Function
REQ-003 SHALL register vi_vs and vi_de once; boundary = registered vs rising edge (vs_q & ~vs_qq). Apply actions occur the cycle after the boundary is detected.
REQ-004 SHALL run a 4-state FSM: IDLE=0, WAIT_VS=1, FLUSH=2, RUN=3.
REQ-005 cfg_wr SHALL copy all cfg_* into staging registers and set pend. A cfg_wr while pend=1 overwrites staging (latest wins) and sets sticky ovw.
REQ-006 At a boundary with pend=1, SHALL copy staging to act_* in one cycle and clear pend.
REQ-007 cfg_wr coincident with a boundary: the boundary applies the old staging; the new values are staged and pend stays 1 for the next boundary.
REQ-008 IDLE: vp_mute=1. On a cfg_wr with cfg_cr[0]=1, go to WAIT_VS. A cfg_wr with cfg_cr[0]=0 stages only.
REQ-009 WAIT_VS: at the boundary, apply and go to FLUSH with flush_cnt=FLUSH_FRAMES.
REQ-010 FLUSH: vp_mute=1; flush_cnt decrements at each boundary and reaching 0 goes to RUN. A boundary with pend=1 applies and reloads flush_cnt.
REQ-011 RUN: vp_mute=0. On a boundary apply, go to FLUSH if act_cr[23:1] changes; stay RUN if only non-CR words change.
REQ-012 Any applied act_cr[0]=0 (from WAIT_VS, FLUSH or RUN) SHALL go to IDLE.
REQ-013 busy = pend | (state==WAIT_VS) | (state==FLUSH).
REQ-014 Pixel counter SHALL count vi_de cycles per line. On the de falling edge: compare to H_DISP, set sticky werr if unequal, increment the line counter, clear the pixel counter. Both counters are 12-bit and saturate at 4095.
REQ-015 At each boundary, SHALL compare the line counter to V_DISP (sticky herr if unequal) and clear both counters. The first boundary after reset skips the compare.
REQ-016 frame_cnt SHALL increment at every boundary, wrapping at 0xFFFF->0.
REQ-017 irq SHALL pulse one cycle with the boundary action, only when state==RUN before the boundary.
REQ-018 vp_sr layout:
- [1:0] state
- [2] pend
- [3] ovw
- [4] werr
- [5] herr
- [6] vp_mute
- [11:8] flush_cnt
- [31:16] frame_cnt
- others 0
REQ-019 sr_clr SHALL clear ovw/werr/herr. A set event in the same cycle wins.

Reset
REQ-020 rst SHALL set: act_* = 0, staging = 0, pend = 0, state = IDLE, vp_mute = 1, busy = 0, irq = 0, frame_cnt = 0, counters = 0, sticky bits = 0, first-frame flag = 1.
REQ-021 rst mid-frame or mid-flush SHALL abandon all pending work; no partial apply.

Verification
REQ-022 Scenarios:
- Reset, cfg_wr cr=0x0000_0203, three 1280x720 frames, FLUSH_FRAMES=2 -> act_cr=0x203 one cycle after the first boundary; vp_mute deasserts after the third boundary; irq first pulses at the fourth boundary.
- In RUN, cfg_wr threshold=0x0000_4020 only -> applied at the next boundary; state stays RUN, vp_mute stays 0.
- Two cfg_wr (cr=0x203 then 0x8203) in one frame -> ovw=1; act_cr=0x8203; FLUSH entered.
- cfg_wr on the exact boundary cycle -> old staging applied; pend=1; new value applied at the following boundary.
- Frame with one 1279-pixel line and 719 lines -> werr=1, herr=1. sr_clr -> both 0. First frame after reset sets no herr.
- rst asserted during FLUSH with pend=1 -> all outputs at reset values the next cycle; frame_cnt 0xFFFF wraps to 0 on a later boundary.

Source files
------------

// File: rtl/vp_seq.sv
// Video-pipe configuration sequencer: stages software configuration, applies it
// on input vsync boundaries, mutes the datapath while the pipeline flushes, and
// reports line/frame geometry errors against the expected display size.
module vp_seq #(
    parameter int H_DISP       = 1280,
    parameter int V_DISP       = 720,
    parameter int FLUSH_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cfg_cr,
    input  logic [31:0] cfg_start,
    input  logic [31:0] cfg_end,
    input  logic [31:0] cfg_scaler,
    input  logic [31:0] cfg_threshold,
    input  logic        cfg_wr,
    input  logic        sr_clr,
    input  logic        vi_vs,
    input  logic        vi_de,
    output logic [31:0] act_cr,
    output logic [31:0] act_start,
    output logic [31:0] act_end,
    output logic [31:0] act_scaler,
    output logic [31:0] act_threshold,
    output logic        vp_mute,
    output logic        busy,
    output logic [31:0] vp_sr,
    output logic [15:0] frame_cnt,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        FLUSH   = 2'd2,
        RUN     = 2'd3
    } state_t;

    localparam logic [11:0] H_EXP      = 12'(H_DISP);
    localparam logic [11:0] V_EXP      = 12'(V_DISP);
    localparam logic [11:0] CNT_MAX    = 12'hFFF;
    localparam logic [3:0]  FLUSH_LOAD = 4'(FLUSH_FRAMES);

    logic [31:0] stg_cr, stg_start, stg_end, stg_scaler, stg_threshold;
    logic        pend, ovw, werr, herr, first_frame;
    logic        vs_q, vs_qq, de_q, de_qq;
    logic        boundary, de_fall;
    logic [11:0] pix_cnt, line_cnt;
    logic [3:0]  flush_cnt;
    state_t      state, state_d;
    logic        apply, flush_load, flush_dec;

    assign boundary = vs_q & ~vs_qq;
    assign de_fall  = de_qq & ~de_q;

    // Register the video timing inputs once and keep one more stage for edge detection.
    // NOTE: every clocked block uses non-blocking assignments so all registers sample
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q  <= 1'b0;
            vs_qq <= 1'b0;
            de_q  <= 1'b0;
            de_qq <= 1'b0;
        end else begin
            vs_q  <= vi_vs;
            vs_qq <= vs_q;
            de_q  <= vi_de;
            de_qq <= de_q;
        end
    end

    // Staging, active configuration, pending flag and overwrite status.
    always_ff @(posedge clk) begin
        if (rst) begin
            stg_cr        <= '0;
            stg_start     <= '0;
            stg_end       <= '0;
            stg_scaler    <= '0;
            stg_threshold <= '0;
            act_cr        <= '0;
            act_start     <= '0;
            act_end       <= '0;
            act_scaler    <= '0;
            act_threshold <= '0;
            pend          <= 1'b0;
            ovw           <= 1'b0;
        end else begin
            if (cfg_wr) begin
                stg_cr        <= cfg_cr;
                stg_start     <= cfg_start;
                stg_end       <= cfg_end;
                stg_scaler    <= cfg_scaler;
                stg_threshold <= cfg_threshold;
            end
            // Apply reads the pre-edge staging, so a write on the boundary cycle
            // is held for the next boundary instead of leaking into this one.
            if (apply) begin
                act_cr        <= stg_cr;
                act_start     <= stg_start;
                act_end       <= stg_end;
                act_scaler    <= stg_scaler;
                act_threshold <= stg_threshold;
            end
            if (cfg_wr)
                pend <= 1'b1;
            else if (apply)
                pend <= 1'b0;
            if (cfg_wr && pend)
                ovw <= 1'b1;
            else if (sr_clr)
                ovw <= 1'b0;
        end
    end

    // Next-state, apply decision and mute output of the sequencer.
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d    = state;
        apply      = 1'b0;
        flush_load = 1'b0;
        flush_dec  = 1'b0;
        vp_mute    = (state != RUN);
        if (boundary && state != IDLE) begin
            if (pend) begin
                apply = 1'b1;
                if (!stg_cr[0]) begin
                    state_d = IDLE;
                end else if (state == RUN && stg_cr[23:1] == act_cr[23:1]) begin
                    state_d = RUN;
                end else begin
                    state_d    = FLUSH;
                    flush_load = 1'b1;
                end
            end else if (state == FLUSH) begin
                flush_dec = 1'b1;
                if (flush_cnt <= 4'd1)
                    state_d = RUN;
            end
        end
        if (state == IDLE && cfg_wr && cfg_cr[0])
            state_d = WAIT_VS;
    end

    // State register and flush frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= 4'd0;
        end else begin
            state <= state_d;
            if (flush_load)
                flush_cnt <= FLUSH_LOAD;
            else if (flush_dec)
                flush_cnt <= flush_cnt - 4'd1;
        end
    end

    // Frame bookkeeping: frame counter, RUN-only interrupt, line-count check.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt   <= 16'd0;
            irq         <= 1'b0;
            first_frame <= 1'b1;
            herr        <= 1'b0;
        end else begin
            irq <= boundary && (state == RUN);
            if (boundary) begin
                frame_cnt   <= frame_cnt + 16'd1;
                first_frame <= 1'b0;
            end
            // The first boundary after reset closes a partial frame, so it is not judged.
            if (boundary && !first_frame && line_cnt != V_EXP)
                herr <= 1'b1;
            else if (sr_clr)
                herr <= 1'b0;
        end
    end

    // Pixel and line counters with the per-line width check.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt  <= 12'd0;
            line_cnt <= 12'd0;
            werr     <= 1'b0;
        end else begin
            if (boundary) begin
                pix_cnt  <= 12'd0;
                line_cnt <= 12'd0;
            end else if (de_fall) begin
                pix_cnt <= 12'd0;
                if (line_cnt != CNT_MAX)
                    line_cnt <= line_cnt + 12'd1;
            end else if (de_q && pix_cnt != CNT_MAX) begin
                pix_cnt <= pix_cnt + 12'd1;
            end
            if (de_fall && pix_cnt != H_EXP)
                werr <= 1'b1;
            else if (sr_clr)
                werr <= 1'b0;
        end
    end

    assign busy  = pend | (state == WAIT_VS) | (state == FLUSH);
    assign vp_sr = {frame_cnt, 4'h0, flush_cnt, 1'b0, vp_mute, herr, werr, ovw, pend, state};

endmodule
